// File: rtl/ov7670_cfg_sequencer.sv
// Walks a camera register table held in a synchronous ROM and issues one SCCB
// write per entry, with NACK retry, timed-delay entries and an end-of-table marker.
module ov7670_cfg_sequencer #(
    parameter int          CLK_FREQ  = 25_000_000,
    parameter int          DELAY_MS  = 10,
    parameter int          ROM_AW    = 8,
    parameter int          MAX_RETRY = 3,
    parameter logic [15:0] END_WORD  = 16'hFFFF,
    parameter logic [15:0] DLY_WORD  = 16'hFFF0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cfg_start,
    output logic              o_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_err,
    output logic [ROM_AW-1:0] o_err_index,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_start,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_din,
    input  logic              i_sccb_ready,
    input  logic              i_sccb_done,
    input  logic              i_sccb_ack
);

    localparam int DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
    localparam int DW        = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam int RW        = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ROM_REQ,
        S_ROM_WAIT,
        S_DECODE,
        S_ARM,
        S_START,
        S_WAIT_DONE,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state;
    logic [ROM_AW-1:0] index;
    logic [RW-1:0]     retry;
    logic [DW-1:0]     delay_cnt;

    // NOTE: every register, outputs included, sits in this one async-reset block,
    // so asserting i_rstn clears the SCCB request without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_IDLE;
            index        <= '0;
            retry        <= '0;
            delay_cnt    <= '0;
            o_busy       <= 1'b0;
            o_cfg_done   <= 1'b0;
            o_cfg_err    <= 1'b0;
            o_err_index  <= '0;
            o_rom_addr   <= '0;
            o_sccb_start <= 1'b0;
            o_sccb_addr  <= '0;
            o_sccb_din   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cfg_start) begin
                        index      <= '0;
                        o_cfg_done <= 1'b0;
                        o_cfg_err  <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= S_ROM_REQ;
                    end
                end
                S_ROM_REQ: begin
                    o_rom_addr <= index;
                    state      <= S_ROM_WAIT;
                end
                S_ROM_WAIT: state <= S_DECODE;
                S_DECODE: begin
                    if (i_rom_data == END_WORD) begin
                        state <= S_DONE;
                    end else if (i_rom_data == DLY_WORD) begin
                        delay_cnt <= DW'(DELAY_CYC - 1);
                        state     <= S_DELAY;
                    end else begin
                        o_sccb_addr <= i_rom_data[15:8];
                        o_sccb_din  <= i_rom_data[7:0];
                        retry       <= '0;
                        state       <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_sccb_ready) begin
                        o_sccb_start <= 1'b1;
                        state        <= S_START;
                    end
                end
                // The master signals acceptance by dropping ready.
                S_START: begin
                    if (!i_sccb_ready) begin
                        o_sccb_start <= 1'b0;
                        state        <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_sccb_done) begin
                        if (i_sccb_ack) begin
                            state <= S_NEXT;
                        end else if (int'(retry) + 1 < MAX_RETRY) begin
                            retry <= retry + 1'b1;
                            state <= S_ARM;
                        end else begin
                            o_err_index <= index;
                            o_cfg_err   <= 1'b1;
                            state       <= S_FAIL;
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == '0) begin
                        state <= S_NEXT;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                // The last ROM slot ends the table even without an END_WORD.
                S_NEXT: begin
                    if (index == {ROM_AW{1'b1}}) begin
                        state <= S_DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_ROM_REQ;
                    end
                end
                S_DONE: begin
                    o_cfg_done <= 1'b1;
                    o_busy     <= 1'b0;
                    state      <= S_IDLE;
                end
                S_FAIL: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
